// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with runtime baud divisor, optional parity and 1/2 stop bits
// Ports: clock/reset_n (async active-low); baud_div (clocks per bit, 0/1 -> 2);
//   parity_type (01 odd, 10 even, else none); stop2 (two stop bits);
//   in_valid/in_data/in_ready (FIFO write side); data_tx (serial line, idle high);
//   active_flag (frame or break in progress); done_flag (one-cycle end-of-frame pulse);
//   fifo_count (occupied entries); tx_break (only when UART_TX_BREAK_EN is defined).
// Optional feature macro: UART_TX_BREAK_EN adds the tx_break input and the break states.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    parity_type,
  input  logic                          stop2,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic                          data_tx,
  output logic                          active_flag,
  output logic                          done_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                          tx_break
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK, BRK_HOLD} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       fcnt_q;
  logic              push, pop;
  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d, div_c;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        ptype_q, ptype_d;
  logic              stop2_q, stop2_d, done_q, done_d;
  logic              bit_end, par_en, par_bit, brk_low;
  assign in_ready    = fcnt_q != (AW+1)'(FIFO_DEPTH);
  assign push        = in_valid & in_ready;
  assign fifo_count  = fcnt_q;
  assign done_flag   = done_q;
  assign active_flag = state_q != IDLE;
  assign div_c       = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign bit_end     = cnt_q == div_q - 1'b1;
  assign par_en      = ^ptype_q;
  assign par_bit     = ptype_q[1] ? ^word_q : ~^word_q;
`ifdef UART_TX_BREAK_EN
  assign brk_low = state_q == BRK;
`else
  assign brk_low = 1'b0;
`endif
  assign data_tx = (state_q == START || brk_low) ? 1'b0 :
                   (state_q == DATA)   ? |(word_q & (DATA_W'(1) << bit_q)) :
                   (state_q == PARITY) ? par_bit : 1'b1;
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= in_data;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      fcnt_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      div_q   <= DIV_W'(2);
      ptype_q <= '0;
      stop2_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      fcnt_q  <= fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      div_q   <= div_d;
      ptype_q <= ptype_d;
      stop2_q <= stop2_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    word_d  = word_q;
    div_d   = div_q;
    ptype_d = ptype_q;
    stop2_d = stop2_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: ;
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == 4'(DATA_W-1)) begin
          state_d = par_en ? PARITY : STOP;
          bit_d   = '0;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == {3'b0, stop2_q}) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      BRK: begin
        cnt_d = '0;
        bit_d = '0;
        if (!tx_break) state_d = BRK_HOLD;
      end
      BRK_HOLD: if (bit_end) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == 4'd1) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // Any path that lands in IDLE (including the last stop clock) may start the next frame at once.
    if (state_d == IDLE) begin
`ifdef UART_TX_BREAK_EN
      if (tx_break) begin
        state_d = BRK;
        div_d   = div_c;
        bit_d   = '0;
        cnt_d   = '0;
      end else
`endif
      if (fcnt_q != '0) begin
        pop     = 1'b1;
        state_d = START;
        word_d  = mem_q[rd_q];
        div_d   = div_c;
        ptype_d = parity_type;
        stop2_d = stop2;
        bit_d   = '0;
        cnt_d   = '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;
  logic        clock = 1'b0, reset_n = 1'b0, stop2 = 1'b0, in_valid = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_type = 2'b00;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, data_tx, active_flag, done_flag;
  logic [2:0]  fifo_count;
`ifdef UART_TX_BREAK_EN
  logic        tx_break = 1'b0;
`endif
  int n_chk = 0, n_fail = 0;
  bit mon_en = 1'b1, mon_busy = 1'b0;
  typedef struct {
    logic [7:0] word;
    int         div;
    bit         par_en;
    logic       par_bit;
    int         len;
    int         nxt;
  } exp_t;
  exp_t exp_q[$];

  uart_tx_fifo dut (
    .clock(clock), .reset_n(reset_n), .baud_div(baud_div), .parity_type(parity_type),
    .stop2(stop2), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .data_tx(data_tx), .active_flag(active_flag), .done_flag(done_flag),
    .fifo_count(fifo_count)
`ifdef UART_TX_BREAK_EN
    , .tx_break(tx_break)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // nxt: 0 line idles after frame, 1 next frame follows with no gap, 2 break follows
  task automatic add(input logic [7:0] w, input int div, input bit pe, input logic pb,
                     input int len, input int nxt);
    exp_t e;
    e.word = w; e.div = div; e.par_en = pe; e.par_bit = pb; e.len = len; e.nxt = nxt;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0 && !mon_busy && !active_flag) return;
      @(negedge clock);
    end
    n_chk++;
    n_fail++;
    $display("FAIL drain_timeout: %0d frames still expected, active=%0b", exp_q.size(), active_flag);
  endtask

  function automatic logic exp_bit(input exp_t e, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return e.word[k-1];
    if (e.par_en && k == 9) return e.par_bit;
    return 1'b1;
  endfunction

  initial begin : monitor
    exp_t e;
    bit   have = 1'b0;
    logic d0 = 1'b0;
    forever begin
      if (!have) @(negedge clock);
      have = 1'b0;
      if (mon_en && reset_n && data_tx === 1'b0) begin
        if (exp_q.size() == 0) chk("unexpected_start", {7'd0, data_tx}, 8'd1);
        else begin
          mon_busy = 1'b1;
          e = exp_q.pop_front();
          for (int i = 0; i < e.len; i++) begin
            if (i != 0) @(negedge clock);
            chk($sformatf("frame_%0h_clk%0d", e.word, i), {5'd0, data_tx, active_flag, done_flag},
                {5'd0, exp_bit(e, i / e.div), 1'b1, (i == 0) ? d0 : 1'b0});
          end
          @(negedge clock);
          chk($sformatf("done_%0h", e.word), {5'd0, data_tx, active_flag, done_flag},
              (e.nxt == 0) ? 8'b101 : 8'b011);
          d0 = (e.nxt == 1);
          if (e.nxt == 2) begin
            for (int i = 0; i < 2000 && data_tx === 1'b0; i++) @(negedge clock);
            chk("brk_release", {5'd0, data_tx, active_flag, done_flag}, 8'b110);
            for (int i = 1; i < 2 * e.div; i++) begin
              @(negedge clock);
              chk("brk_hold", {5'd0, data_tx, active_flag, done_flag}, 8'b110);
            end
            @(negedge clock);
          end
          mon_busy = 1'b0;
          have = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    repeat (2) @(negedge clock);
    chk("rst_tx", {7'd0, data_tx}, 8'd1);
    chk("rst_active", {7'd0, active_flag}, 8'd0);
    chk("rst_done", {7'd0, done_flag}, 8'd0);
    chk("rst_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_count", {5'd0, fifo_count}, 8'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    add(8'hA5, 4, 0, 0, 40, 0);
    push(8'hA5);
    chk("lat_count_pushed", {5'd0, fifo_count}, 8'd1);
    chk("lat_tx_idle", {7'd0, data_tx}, 8'd1);
    @(negedge clock);
    chk("lat_count_popped", {5'd0, fifo_count}, 8'd0);
    chk("lat_active", {7'd0, active_flag}, 8'd1);
    drain();
    parity_type = 2'b01;
    add(8'h07, 4, 1, 0, 44, 0);
    push(8'h07);
    drain();
    parity_type = 2'b10;
    add(8'h07, 4, 1, 1, 44, 0);
    push(8'h07);
    drain();
    stop2 = 1'b1;
    add(8'h07, 4, 1, 1, 48, 0);
    push(8'h07);
    drain();
    parity_type = 2'b11;
    stop2 = 1'b0;
    add(8'h3C, 4, 0, 0, 40, 0);
    push(8'h3C);
    drain();
    parity_type = 2'b00;
    baud_div = 16'd8;
    add(8'h11, 8, 0, 0, 80, 1);
    add(8'h22, 8, 0, 0, 80, 1);
    add(8'h33, 8, 0, 0, 80, 1);
    add(8'h44, 8, 0, 0, 80, 1);
    add(8'h55, 8, 0, 0, 80, 0);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    push(8'h66);
    chk("full_ready", {7'd0, in_ready}, 8'd0);
    chk("full_count", {5'd0, fifo_count}, 8'd4);
    drain();
    chk("empty_count", {5'd0, fifo_count}, 8'd0);
    chk("empty_ready", {7'd0, in_ready}, 8'd1);
    baud_div = 16'd4;
    add(8'h5A, 4, 0, 0, 40, 1);
    add(8'hC3, 10, 0, 0, 100, 0);
    push(8'h5A);
    push(8'hC3);
    repeat (8) @(negedge clock);
    baud_div = 16'd10;
    drain();
    baud_div = 16'd0;
    add(8'h81, 2, 0, 0, 20, 0);
    push(8'h81);
    drain();
    baud_div = 16'd1;
    add(8'h0F, 2, 0, 0, 20, 0);
    push(8'h0F);
    drain();
    baud_div = 16'd4;
    mon_en = 1'b0;
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    repeat (8) @(negedge clock);
    chk("pre_rst_count", {5'd0, fifo_count}, 8'd3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tx", {7'd0, data_tx}, 8'd1);
    chk("mid_rst_count", {5'd0, fifo_count}, 8'd0);
    chk("mid_rst_active", {7'd0, active_flag}, 8'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      chk($sformatf("post_rst_idle_%0d", i), {5'd0, data_tx, active_flag, done_flag}, 8'b100);
    end
    mon_en = 1'b1;
`ifdef UART_TX_BREAK_EN
    add(8'h55, 4, 0, 0, 40, 2);
    add(8'h0F, 4, 0, 0, 40, 0);
    push(8'h55);
    push(8'h0F);
    repeat (8) @(negedge clock);
    tx_break = 1'b1;
    repeat (60) @(negedge clock);
    chk("brk_low", {6'd0, data_tx, active_flag}, 8'b01);
    tx_break = 1'b0;
    drain();
`endif
    repeat (4) @(negedge clock);
    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
